bcd_serial_subtractor: RTL and testbench
========================================

BCD_SERIAL_SUBTRACTOR -- requirements
Module: bcd_serial_subtractor

Interface
REQ-001 The block SHALL have parameter DIGITS, default 6, giving the number of packed BCD digits per operand (legal range 1..8).
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single rising-edge clock.
REQ-003 Port rst_n SHALL be an input, 1 bit wide, and is the asynchronous, active-low reset.
REQ-004 Port start SHALL be an input, 1 bit wide, and requests an operation; it is sampled only when ready=1.
REQ-005 Port a SHALL be an input, 4*DIGITS bits wide, carrying the minuend with digit 0 in bits [3:0].
REQ-006 Port b SHALL be an input, 4*DIGITS bits wide, carrying the subtrahend in the same packing as a.
REQ-007 Port ready SHALL be an output, 1 bit wide, and is high when idle and able to accept start.
REQ-008 Port done SHALL be an output, 1 bit wide, and is a one-cycle pulse when the result is valid.
REQ-009 Port diff SHALL be an output, 4*DIGITS bits wide, carrying the BCD difference.
REQ-010 Port borrow SHALL be an output, 1 bit wide, and is set when a<b, with diff holding the ten's complement.
REQ-011 Port invalid SHALL be an output, 1 bit wide, and is set when any captured digit of a or b is greater than 9.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; ready=1 only in IDLE.
REQ-013 In IDLE with start=1, the block SHALL capture a and b into internal registers, clear the borrow chain, set digit index=0 and enter RUN.
REQ-014 In RUN, the block SHALL process exactly one digit per cycle, LSD first, as follows:
- t = a_d - b_d - borrow_in
- if t<0, the digit result is t+10 and borrow_out=1
- otherwise the digit result is t and borrow_out=0
REQ-015 The digit result SHALL be written into the diff register at the indexed position, and borrow_out SHALL feed the next digit.
REQ-016 After digit DIGITS-1 is processed, the FSM SHALL enter DONE, and borrow SHALL equal the final borrow_out.
REQ-017 DONE SHALL last one cycle with done=1 and return to IDLE; latency from the start-accept edge to done high is DIGITS+1 cycles.
REQ-018 diff, borrow and invalid SHALL hold their values from DONE until the next accepted start.
REQ-019 On an accepted start, diff, borrow and invalid SHALL be cleared in the same edge.
REQ-020 start asserted outside IDLE SHALL be ignored, with no queuing.
REQ-021 Changes to a or b after capture SHALL NOT affect the operation in progress.
REQ-022 invalid SHALL be evaluated on captured operands at the accept edge; if set, the sequence still runs for full latency, but diff SHALL be forced to all zeros and borrow=0 at DONE.
REQ-023 Equal operands SHALL give diff=0 and borrow=0.
REQ-024 If start is held high continuously, a new operation SHALL be accepted on every IDLE cycle, giving a period of DIGITS+2 cycles.

Reset
REQ-025 On rst_n=0, asynchronously and in any state including mid-RUN, the block SHALL force the following values:
- state=IDLE
- ready=1, done=0
- diff=0, borrow=0, invalid=0
- digit index=0
- captured operands=0
REQ-026 The first start SHALL be accepted on the first rising clk edge after rst_n deasserts.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE, RUN, DONE), the constant BCD_RADIX=10 and the constant BCD_MAX_DIGIT=9.
REQ-028 The single-digit borrow logic SHALL be a combinational sub-module bcd_digit_sub with ports a[3:0], b[3:0], bin → d[3:0], bout, instantiated once and muxed by digit index.
REQ-029 The digit index counter SHALL be sized as $clog2(DIGITS+1) bits.

Verification
REQ-030 With DIGITS=6, a=0x123456, b=0x012345, and start pulsed → done exactly 7 cycles after accept, diff=0x111111, borrow=0, invalid=0.
REQ-031 a=0x000000, b=0x000001 → diff=0x999999, borrow=1 (full borrow ripple across all digits).
REQ-032 a=0x10A000, b=0x000001 → invalid=1, diff=0x000000, borrow=0, with done at normal latency.
REQ-033 start re-pulsed during RUN, with a/b changed mid-operation → result matches the originally captured operands, and exactly one done pulse occurs.
REQ-034 rst_n pulsed low during digit 3 of an operation → outputs go to their reset values immediately, no done pulse occurs, and a following operation 0x500000-0x250000 gives diff=0x250000, borrow=0.
REQ-035 start held high for 3 operations → done pulses spaced exactly 8 cycles apart, with ready low throughout each RUN.

Source files
------------

// File: rtl/bcd_serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_subtractor_pkg
// Description : Shared FSM encoding and BCD constants for the serial subtractor.
// Revision    : 1.0
// ============================================================================
package bcd_serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int BCD_RADIX     = 10;
    localparam int BCD_MAX_DIGIT = 9;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_sub.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_sub
// Description : One-digit BCD subtract with borrow in/out (combinational).
// Revision    : 1.0
// ============================================================================
module bcd_digit_sub
    import bcd_serial_subtractor_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    // 5-bit two's complement covers -16..15 even for non-BCD digits
    logic [4:0] w_t;

    always_comb begin
        w_t  = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
        bout = w_t[4];
        d    = w_t[4] ? (w_t[3:0] + 4'(BCD_RADIX)) : w_t[3:0];
    end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_subtractor
// Description : Digit-serial packed-BCD subtractor, LSD first, one digit/cycle.
// Revision    : 1.0
// ============================================================================
module bcd_serial_subtractor
    import bcd_serial_subtractor_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  borrow,
    output logic                  invalid
);

    localparam int IDX_W = $clog2(DIGITS + 1);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DIGITS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_a;
    logic [4*DIGITS-1:0] r_b;
    logic [4*DIGITS-1:0] r_diff;
    logic                r_borrow;
    logic                r_invalid;
    logic                r_chain;
    logic                w_accept;
    logic                w_in_invalid;
    logic [3:0]          w_a_dig;
    logic [3:0]          w_b_dig;
    logic [3:0]          w_d;
    logic                w_bout;

    assign w_accept = (r_state == ST_IDLE) && start;

    always_comb begin
        w_in_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'(BCD_MAX_DIGIT)) || (b[4*i +: 4] > 4'(BCD_MAX_DIGIT)))
                w_in_invalid = 1'b1;
        end
    end

    always_comb begin
        w_a_dig = 4'd0;
        w_b_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == i[IDX_W-1:0]) begin
                w_a_dig = r_a[4*i +: 4];
                w_b_dig = r_b[4*i +: 4];
            end
        end
    end

    bcd_digit_sub u_digit_sub (
        .a    (w_a_dig),
        .b    (w_b_dig),
        .bin  (r_chain),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_idx == c_last_idx) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_diff    <= '0;
            r_borrow  <= 1'b0;
            r_invalid <= 1'b0;
            r_chain   <= 1'b0;
        end else if (w_accept) begin
            r_a       <= a;
            r_b       <= b;
            r_diff    <= '0;
            r_borrow  <= 1'b0;
            r_invalid <= w_in_invalid;
            r_idx     <= '0;
            r_chain   <= 1'b0;
        end else if (r_state == ST_RUN) begin
            // Invalid operands leave diff at its cleared all-zero value
            if (!r_invalid) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (r_idx == i[IDX_W-1:0]) r_diff[4*i +: 4] <= w_d;
                end
            end
            r_chain <= w_bout;
            r_idx   <= r_idx + 1'b1;
            if (r_idx == c_last_idx) r_borrow <= w_bout & ~r_invalid;
        end
    end

    assign ready   = (r_state == ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign diff    = r_diff;
    assign borrow  = r_borrow;
    assign invalid = r_invalid;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_serial_subtractor
// Description : Directed vector table plus corner-case sequences for the DUT.
// Revision    : 1.0
// ============================================================================
module tb_bcd_serial_subtractor;

    localparam int DIGITS = 6;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         invalid;

    int n_cmp = 0;
    int n_err = 0;

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .diff    (diff),
        .borrow  (borrow),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         invalid;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept one operation, scramble a/b after capture, return negedges until done
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int rdy_cnt;
        int t_done [3];
        int n;

        vecs[0] = '{24'h123456, 24'h012345, 24'h111111, 1'b0, 1'b0};
        vecs[1] = '{24'h000000, 24'h000001, 24'h999999, 1'b1, 1'b0};
        vecs[2] = '{24'h10A000, 24'h000001, 24'h000000, 1'b0, 1'b1};
        vecs[3] = '{24'h987654, 24'h987654, 24'h000000, 1'b0, 1'b0};
        vecs[4] = '{24'h500000, 24'h250000, 24'h250000, 1'b0, 1'b0};
        vecs[5] = '{24'h123456, 24'h654321, 24'h469135, 1'b1, 1'b0};
        vecs[6] = '{24'h100000, 24'h000001, 24'h099999, 1'b0, 1'b0};
        vecs[7] = '{24'h000000, 24'h999999, 24'h000001, 1'b1, 1'b0};
        vecs[8] = '{24'h999999, 24'h000000, 24'h999999, 1'b0, 1'b0};
        vecs[9] = '{24'h000000, 24'h00000F, 24'h000000, 1'b0, 1'b1};

        // Reset state
        #12;
        check("rst_ready",   {31'd0, ready},   32'd1);
        check("rst_done",    {31'd0, done},    32'd0);
        check("rst_diff",    32'(diff),        32'd0);
        check("rst_borrow",  {31'd0, borrow},  32'd0);
        check("rst_invalid", {31'd0, invalid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd7);
            check($sformatf("v%0d_diff", i),    32'(diff), 32'(vecs[i].diff));
            check($sformatf("v%0d_borrow", i),  {31'd0, borrow},  {31'd0, vecs[i].borrow});
            check($sformatf("v%0d_invalid", i), {31'd0, invalid}, {31'd0, vecs[i].invalid});
            @(negedge clk);
            check($sformatf("v%0d_done_width", i), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_hold_diff", i),  32'(diff), 32'(vecs[i].diff));
        end

        // start re-pulsed during RUN with operands changed: ignored, one done
        @(negedge clk);
        a = 24'h123456; b = 24'h012345; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("repulse_cleared", 32'(diff), 32'd0);
        pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k >= 2 && k <= 4) begin
                start = 1'b1; a = 24'h999999; b = 24'h000000;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                check("repulse_latency", 32'(k), 32'd7);
                check("repulse_diff", 32'(diff), 32'h111111);
            end
            @(negedge clk);
        end
        check("repulse_pulses", 32'(pulses), 32'd1);

        // Asynchronous reset during digit processing
        @(negedge clk);
        a = 24'h999999; b = 24'h000001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready",  {31'd0, ready},  32'd1);
        check("midrst_done",   {31'd0, done},   32'd0);
        check("midrst_diff",   32'(diff),       32'd0);
        check("midrst_borrow", {31'd0, borrow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);
        run_op(24'h500000, 24'h250000, lat);
        check("postrst_latency", 32'(lat), 32'd7);
        check("postrst_diff",    32'(diff), 32'h250000);
        check("postrst_borrow",  {31'd0, borrow}, 32'd0);

        // start held high for three back-to-back operations
        @(negedge clk);
        @(negedge clk);
        a = 24'h000000; b = 24'h000001; start = 1'b1;
        pulses = 0;
        rdy_cnt = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (ready) rdy_cnt++;
            if (done) begin
                if (pulses < 3) t_done[pulses] = k;
                pulses++;
            end
        end
        start = 1'b0;
        check("held_pulses", 32'(pulses), 32'd3);
        check("held_ready_cycles", 32'(rdy_cnt), 32'd3);
        n = (pulses >= 3) ? (t_done[1] - t_done[0]) : -1;
        check("held_gap1", 32'(n), 32'd8);
        n = (pulses >= 3) ? (t_done[2] - t_done[1]) : -1;
        check("held_gap2", 32'(n), 32'd8);
        check("held_diff", 32'(diff), 32'h999999);
        check("held_borrow", {31'd0, borrow}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
